// File: rtl/b8_rr_arbiter.sv
// Eight-way round-robin arbiter with grant hold, optional bounded tenure,
// and a mandatory IDLE turnaround cycle between successive owners.
module b8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Last hold_cnt value of a tenure; preemption fires while sitting on it.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);

  logic [0:0] state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [7:0] hold_q,  hold_d;

  logic [2:0] sel;
  logic       any;
  logic       others;
  logic [7:0] owner_mask;

  // Rotating-priority scan: walk from ptr+7 down to ptr so the nearest wins.
  always_comb begin
    sel = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr_q + 3'(k)]) sel = ptr_q + 3'(k);
    end
  end

  assign any        = |req;
  assign owner_mask = 8'b1 << owner_q;
  assign others     = |(req & ~owner_mask);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          owner_d = sel;
          hold_d  = 8'd0;
          state_d = ST_GRANT;
        end
      end
      default: begin
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q + 3'd1;
        end else if (PREEMPT_EN && others && (hold_q == HOLD_LAST)) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q + 3'd1;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs are purely registered state plus the owner decoder.
  assign busy     = (state_q == ST_GRANT);
  assign grant_id = owner_q;
  assign grant    = owner_mask & {8{busy}};

endmodule

// File: tb/tb_b8_rr_arbiter.sv
// Directed bench for b8_rr_arbiter: one instance with MAX_HOLD=4 and one with
// preemption disabled, checked with immediate assertions one cycle at a time.
module tb_b8_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] req0;
  logic [7:0] grant,  grant0;
  logic [2:0] grant_id, grant_id0;
  logic       busy,   busy0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  b8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .req(req),
    .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  b8_rr_arbiter #(.MAX_HOLD(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0),
    .grant(grant0), .grant_id(grant_id0), .busy(busy0)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    req0  = 8'h00;

    // Reset with every requester asserted
    tick();
    chk("rst_grant_a", grant, 8'h00);
    chk("rst_busy_a", {7'd0, busy}, 8'h00);
    tick();
    chk("rst_grant_b", grant, 8'h00);
    chk("rst_busy_b", {7'd0, busy}, 8'h00);
    chk("rst_id", {5'd0, grant_id}, 8'h00);
    reset = 1'b0;
    tick();
    chk("post_rst_grant", grant, 8'h01);
    chk("post_rst_id", {5'd0, grant_id}, 8'h00);
    chk("post_rst_busy", {7'd0, busy}, 8'h01);

    // Rotation: each owner drops for one cycle after its grant
    for (int i = 0; i < 8; i++) begin
      req = 8'hFF & ~(8'h01 << i);
      tick();
      chk("rot_gap", grant, 8'h00);
      chk("rot_gap_busy", {7'd0, busy}, 8'h00);
      req = 8'hFF;
      tick();
      chk("rot_grant", grant, 8'h01 << ((i + 1) % 8));
      chk("rot_id", {5'd0, grant_id}, 8'((i + 1) % 8));
    end

    // Priority pointer: after 5 releases, 0 beats 5
    req = 8'h00;
    tick();
    chk("pp_idle", grant, 8'h00);
    req = 8'h20;
    tick();
    chk("pp_g5", grant, 8'h20);
    req = 8'h00;
    tick();
    chk("pp_rel5", grant, 8'h00);
    req = 8'h21;
    tick();
    chk("pp_win0", grant, 8'h01);
    chk("pp_win0_id", {5'd0, grant_id}, 8'h00);

    // Preemption with MAX_HOLD=4: requester 2 vs 6
    req = 8'h00;
    tick();
    chk("pre_idle", grant, 8'h00);
    req = 8'h04;
    tick();
    chk("pre_hold1", grant, 8'h04);
    req = 8'h44;
    tick();
    chk("pre_hold2", grant, 8'h04);
    tick();
    chk("pre_hold3", grant, 8'h04);
    tick();
    chk("pre_hold4", grant, 8'h04);
    tick();
    chk("pre_gap", grant, 8'h00);
    tick();
    chk("pre_next", grant, 8'h40);
    chk("pre_next_id", {5'd0, grant_id}, 8'h06);

    // Sole requester for 20 cycles on both instances, then competition
    req = 8'h00;
    tick();
    chk("sole_idle", grant, 8'h00);
    req  = 8'h08;
    req0 = 8'h08;
    tick();
    chk("sole_first", grant, 8'h08);
    chk("nop_first", grant0, 8'h08);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("sole_hold", grant, 8'h08);
    end
    req  = 8'h0A;
    req0 = 8'h0A;
    tick();
    chk("sole_revoke", grant, 8'h00);
    chk("nop_keep_a", grant0, 8'h08);
    tick();
    chk("sole_next", grant, 8'h02);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nop_keep", grant0, 8'h08);
    end
    chk("nop_busy", {7'd0, busy0}, 8'h01);
    req0 = 8'h00;

    // Reset in the middle of a grant to requester 4
    req = 8'h00;
    tick();
    chk("mid_idle", grant, 8'h00);
    req = 8'h10;
    tick();
    chk("mid_g4", grant, 8'h10);
    reset = 1'b1;
    tick();
    chk("mid_rst_grant", grant, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    chk("mid_rst_id", {5'd0, grant_id}, 8'h00);
    reset = 1'b0;
    req   = 8'h11;
    tick();
    chk("mid_after", grant, 8'h01);
    chk("mid_after_id", {5'd0, grant_id}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b8_rr_arbiter.md
# b8_rr_arbiter

Round-robin arbiter that shares one resource among 8 requesters. Each cycle it picks an owner by rotating priority, holds the grant while the owner keeps requesting, and optionally revokes it after a bounded tenure when others are waiting. The one-hot grant vector is produced by passing the registered 3-bit owner index through a 3-to-8 one-hot decoder, gated by `busy`. This block sits between requesting units and a shared bus or functional unit.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum grant tenure in cycles while other requests are pending. 0 disables preemption. Legal range is 0..255.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines; `req[i]` high means requester i wants the resource or is still using it.
- `grant`  out  8  one-hot grant; all zero when no owner.
- `grant_id`  out  3  binary index of the current owner; meaningful only when `busy`=1.
- `busy`  out  1  high while a grant is active.

## Operation

- Registered state:
  - `state` (IDLE, GRANT)
  - `owner` (3 bit)
  - `ptr` (3 bit, highest-priority index)
  - `hold_cnt` (8 bit)
- Output wiring:
  - `grant_id` = `owner`.
  - `busy` = (`state`==GRANT).
  - `grant` = decode(`owner`) AND {8{`busy`}}.
  - All outputs come straight from registers or from the decoder. There is no combinational path from `req` to any output.
- Selection (combinational): scan indices `ptr`, `ptr`+1, ..., `ptr`+7, all mod 8. `sel` is the first index i with `req[i]`=1. `any` = OR of `req`.
- IDLE:
  - If `any`=1: `owner`<=`sel`, `hold_cnt`<=0, go to GRANT.
  - Otherwise stay in IDLE. `ptr` is unchanged.
- GRANT:
  - `others` = OR of `req` with bit `owner` masked.
  - Release: if `req[owner]`=0, go to IDLE and set `ptr`<=`owner`+1 (mod 8, so 7 wraps to 0).
  - Preempt: if `MAX_HOLD`≠0, `req[owner]`=1, `others`=1 and `hold_cnt`==`MAX_HOLD`-1, go to IDLE and set `ptr`<=`owner`+1. The revoked requester must tolerate losing the grant while still requesting. It re-competes at its new, lowest priority.
  - Otherwise stay in GRANT. If `hold_cnt`<`MAX_HOLD`-1, `hold_cnt`<=`hold_cnt`+1. If `others`=0, `hold_cnt` keeps counting but saturates at `MAX_HOLD`-1.
- Consequence of saturation: a sole requester is never preempted. If another request arrives after saturation, preemption happens at the next edge.
- Every grant change passes through one IDLE cycle. This gives a guaranteed dead cycle for bus turnaround; no two grants are ever adjacent.
- Reset: `state`=IDLE, `owner`=0, `ptr`=0, `hold_cnt`=0. Therefore `grant`=8'b0, `grant_id`=3'd0, `busy`=0. Reset overrides everything, including an active grant mid-tenure. Requester 0 has top priority after reset.

## Timing

- Request to grant: if `req` rises before edge k while in IDLE, `grant` is valid after edge k. Latency is 1 cycle.
- Release to grant drop: if `req[owner]` falls before edge k, `grant` is 0 after edge k. The next grant appears after edge k+1 at the earliest.
- Handover period: minimum 2 cycles (1 IDLE + 1 GRANT) between successive owners.
- Preemption: with `MAX_HOLD`=M and constant competition, the owner holds `grant` for exactly M cycles, then there is 1 IDLE cycle.
- Starvation bound: a requester that keeps `req` high waits at most 7 tenures plus 8 IDLE cycles.
- `req` pulses shorter than one cycle that are not sampled at an edge are ignored.

## Test plan

- Reset and idle:
  - Stimulus: assert `reset` for 2 cycles with `req`=8'hFF.
  - Required: `grant`=0 and `busy`=0 during reset. `grant`=8'h01 and `grant_id`=0 one cycle after reset release.
- Rotation and wrap-around:
  - Stimulus: `req`=8'hFF, each owner drops its `req` bit 1 cycle after being granted, then re-raises it.
  - Required: grants in order 01,02,04,...,80,01, with one zero cycle between each. `ptr` wraps from 7 to 0.
- Priority pointer:
  - Stimulus: requester 5 is granted and released; then `req`=8'b0010_0001 (requesters 0 and 5).
  - Required: requester 0 wins, because `ptr`=6 scans 6,7,0 first.
- Preemption:
  - Stimulus: `MAX_HOLD`=4, requester 2 holds `req`, requester 6 requests from cycle 1.
  - Required: `grant`=8'h04 for exactly 4 cycles, then 1 zero cycle, then `grant`=8'h40.
- Sole requester and disabled preemption:
  - Stimulus 1: `MAX_HOLD`=4, requester 3 alone for 20 cycles, then requester 1 requests.
  - Required 1: `grant`=8'h08 throughout the 20 cycles. It is revoked at the next edge after requester 1 arrives, because `hold_cnt` is saturated.
  - Stimulus 2: `MAX_HOLD`=0 with the same competition.
  - Required 2: the grant is never revoked.
- Reset mid-grant:
  - Stimulus: assert `reset` while `grant`=8'h10.
  - Required: `grant`=0 after that edge. After reset release, with `req`=8'h11, requester 0 wins.
